// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LOAD,
    FLUSH,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  // Byte address of the last instruction of a count-word image.
  function automatic logic [31:0] calc_last_pc(input logic [15:0] count);
    return (count == 16'd0) ? 32'd0 : {14'd0, count - 16'd1, 2'b00};
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  logic [1:0]  lane;
  logic [23:0] lanes;

  // Lane counter and the three lower byte lanes; the top byte is taken live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= 2'd0;
      lanes <= 24'd0;
    end else if (clear) begin
      lane <= 2'd0;
    end else if (shift_en) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    lanes[7:0]   <= data;
        2'd1:    lanes[15:8]  <= data;
        2'd2:    lanes[23:16] <= data;
        default: ;
      endcase
    end
  end

  assign word_valid_c = shift_en && (lane == 2'(WORD_BYTES - 1));
  assign word_c       = {data, lanes};

endmodule

// File: rtl/imem_loader.sv
// Streams a counted little-endian image into instruction memory while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [31:0]       last_pc
);

  state_t            state, state_n;
  logic [15:0]       count_q, count_n, hdr;
  logic [ADDR_W-1:0] widx, widx_n, waddr_n;
  logic [31:0]       wdata_n, last_pc_n, word_c;
  logic              we_n, cpu_rst_n, done_n, err_n;
  logic              xfer, shift_en, pack_clear, word_valid_c;

  assign in_ready = (state == HDR_LO) || (state == HDR_HI) || (state == LOAD);
  assign xfer     = in_valid && in_ready;
  assign shift_en = xfer && (state == LOAD);
  assign hdr      = {in_data, count_q[7:0]};

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (pack_clear),
    .shift_en     (shift_en),
    .data         (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HDR_LO;
      count_q <= 16'd0;
      widx    <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= 32'd0;
      cpu_rst <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      last_pc <= 32'd0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      widx    <= widx_n;
      we      <= we_n;
      waddr   <= waddr_n;
      wdata   <= wdata_n;
      cpu_rst <= cpu_rst_n;
      done    <= done_n;
      err     <= err_n;
      last_pc <= last_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count_q;
    widx_n     = widx;
    we_n       = 1'b0;
    waddr_n    = waddr;
    wdata_n    = wdata;
    cpu_rst_n  = cpu_rst;
    done_n     = done;
    err_n      = err;
    last_pc_n  = last_pc;
    pack_clear = 1'b0;
    case (state)
      HDR_LO: if (xfer) begin
        count_n = {8'd0, in_data};
        state_n = HDR_HI;
      end
      HDR_HI: if (xfer) begin
        count_n = hdr;
        if (hdr == 16'd0) begin
          last_pc_n = 32'd0;
          cpu_rst_n = 1'b0;
          done_n    = 1'b1;
          state_n   = DONE;
        end else if (32'(hdr) > DEPTH) begin
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          widx_n     = '0;
          pack_clear = 1'b1;
          last_pc_n  = calc_last_pc(hdr);
          state_n    = LOAD;
        end
      end
      LOAD: if (word_valid_c) begin
        we_n    = 1'b1;
        waddr_n = widx;
        wdata_n = word_c;
        widx_n  = widx + 1'b1;
        if (16'(widx) == count_q - 16'd1) state_n = FLUSH;
      end
      FLUSH: begin
        cpu_rst_n = 1'b0;
        done_n    = 1'b1;
        state_n   = DONE;
      end
      DONE, ERR: if (reload) begin
        cpu_rst_n = 1'b1;
        done_n    = 1'b0;
        err_n     = 1'b0;
        state_n   = HDR_LO;
      end
      default: state_n = HDR_LO;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              reload = 1'b0;
  logic              in_ready, we, cpu_rst, done, err;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata, last_pc;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .we(we), .waddr(waddr), .wdata(wdata), .cpu_rst(cpu_rst),
    .done(done), .err(err), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int max_gap = 0;
  int we_cnt = 0;
  int wlog[$];
  logic [31:0] mem [0:DEPTH-1];

  // Reference model: mode 0 loading, 1 done, 2 error.
  int          m_mode, m_hdr, m_count, m_bytes, m_waddr;
  logic [31:0] m_word, m_wdata, m_last_pc;
  bit          m_we, m_cpu_rst, m_done, m_err;

  function automatic bit m_ready();
    return (m_mode == 0) && !(m_hdr == 2 && m_bytes == 4 * m_count);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_hdr = 0; m_count = 0; m_bytes = 0; m_word = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0;
    m_cpu_rst = 1; m_done = 0; m_err = 0; m_last_pc = 0;
  endtask

  task automatic m_step();
    m_we = 0;
    if (m_mode == 0) begin
      if (m_hdr == 2 && m_bytes == 4 * m_count) begin
        m_mode = 1; m_done = 1; m_cpu_rst = 0;
      end else if (in_valid) begin
        if (m_hdr == 0) begin
          m_count = int'(in_data); m_hdr = 1;
        end else if (m_hdr == 1) begin
          m_count = m_count + 256 * int'(in_data); m_hdr = 2;
          if (m_count == 0) begin
            m_mode = 1; m_done = 1; m_cpu_rst = 0; m_last_pc = 0;
          end else if (m_count > int'(DEPTH)) begin
            m_mode = 2; m_err = 1;
          end else begin
            m_last_pc = 32'((m_count - 1) * 4); m_bytes = 0; m_word = 0;
          end
        end else begin
          m_word = m_word | (32'(in_data) << (8 * (m_bytes % 4)));
          m_bytes++;
          if (m_bytes % 4 == 0) begin
            m_we = 1; m_waddr = m_bytes / 4 - 1; m_wdata = m_word; m_word = 0;
          end
        end
      end
    end else if (reload) begin
      m_mode = 0; m_hdr = 0; m_count = 0; m_bytes = 0; m_word = 0;
      m_cpu_rst = 1; m_done = 0; m_err = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_ready()));
    check("we", 32'(we), 32'(m_we));
    check("cpu_rst", 32'(cpu_rst), 32'(m_cpu_rst));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    check("last_pc", last_pc, m_last_pc);
    if (m_we) begin
      check("waddr", 32'(waddr), 32'(m_waddr));
      check("wdata", wdata, m_wdata);
    end
    if (we === 1'b1) begin
      we_cnt++;
      mem[waddr] = wdata;
      wlog.push_back(int'(waddr));
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g, n;
    bit acc;
    g = $urandom_range(0, max_gap);
    repeat (g) begin in_valid = 1'b0; in_data = 8'($urandom); cyc(); end
    in_valid = 1'b1; in_data = b; acc = 0; n = 0;
    while (!acc && n < 64) begin
      @(negedge clk); acc = in_ready;
      cyc(); n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL handshake: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic send_hdr(input logic [15:0] c);
    send_byte(c[7:0]); send_byte(c[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_status();
    int n = 0;
    while (!(done || err) && n < 300) begin cyc(); n++; end
    if (!(done || err)) begin
      vectors++; miscompares++;
      $display("FAIL wait_status: got done=%b err=%b expected one high within 300 cycles", done, err);
    end
    cyc();
  endtask

  task automatic pulse_reload();
    reload = 1'b1; cyc(); reload = 1'b0;
  endtask

  initial begin
    int base, c;
    repeat (3) cyc();
    check("reset cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    cyc();

    // 1: fifteen back-to-back words
    base = we_cnt;
    send_hdr(16'd15);
    for (int i = 0; i < 15; i++) send_word(32'h13 + 32'(i));
    wait_status();
    check("t1 we count", 32'(we_cnt - base), 32'd15);
    check("t1 last_pc", last_pc, 32'h38);
    check("t1 mem14", mem[14], 32'h21);
    check("t1 done", 32'(done), 32'd1);

    // 2: one word with gaps
    pulse_reload();
    max_gap = 3; base = we_cnt;
    send_hdr(16'd1);
    send_word(32'h00100093);
    wait_status();
    check("t2 we count", 32'(we_cnt - base), 32'd1);
    check("t2 mem0", mem[0], 32'h00100093);

    // 3: oversize header
    pulse_reload();
    base = we_cnt;
    send_hdr(16'h0401);
    repeat (3) cyc();
    in_valid = 1'b1; repeat (3) cyc(); in_valid = 1'b0;
    check("t3 err", 32'(err), 32'd1);
    check("t3 in_ready", 32'(in_ready), 32'd0);
    check("t3 we count", 32'(we_cnt - base), 32'd0);
    pulse_reload();
    check("t3 err cleared", 32'(err), 32'd0);
    check("t3 ready again", 32'(in_ready), 32'd1);

    // 4: empty image
    send_hdr(16'd0);
    in_valid = 1'b1; repeat (4) cyc(); in_valid = 1'b0;
    check("t4 done", 32'(done), 32'd1);
    check("t4 last_pc", last_pc, 32'd0);
    check("t4 we count", 32'(we_cnt - base), 32'd0);

    // 5: reset in the middle of word 3
    pulse_reload();
    send_hdr(16'd5);
    send_word(32'hA0A0A0A0); send_word(32'hB1B1B1B1);
    send_byte(8'hC2); send_byte(8'hC3);
    #1 rst = 1'b1;
    #1;
    check("t5 rst cpu_rst", 32'(cpu_rst), 32'd1);
    check("t5 rst we", 32'(we), 32'd0);
    check("t5 rst last_pc", last_pc, 32'd0);
    check("t5 rst waddr", 32'(waddr), 32'd0);
    check("t5 rst in_ready", 32'(in_ready), 32'd1);
    cyc(); rst = 1'b0; cyc();
    base = wlog.size();
    send_hdr(16'd2);
    send_word(32'h11111111); send_word(32'h22222222);
    wait_status();
    check("t5 addr0", 32'(wlog[base]), 32'd0);
    check("t5 addr1", 32'(wlog[base + 1]), 32'd1);

    // 6: reload ignored during LOAD, honoured in DONE
    pulse_reload();
    send_hdr(16'd3);
    send_word(32'h01020304);
    pulse_reload();
    send_word(32'h05060708); send_word(32'h090A0B0C);
    wait_status();
    check("t6 done", 32'(done), 32'd1);
    check("t6 mem2", mem[2], 32'h090A0B0C);
    pulse_reload();
    check("t6 cpu_rst", 32'(cpu_rst), 32'd1);
    check("t6 done low", 32'(done), 32'd0);
    base = wlog.size();
    send_hdr(16'd2);
    send_word(32'hDEADBEEF); send_word(32'hCAFEF00D);
    wait_status();
    check("t6 first addr", 32'(wlog[base]), 32'd0);
    check("t6 mem0", mem[0], 32'hDEADBEEF);

    // Random images
    for (int k = 0; k < 8; k++) begin
      pulse_reload();
      max_gap = $urandom_range(0, 3);
      c = ($urandom_range(0, 5) == 0) ? int'(DEPTH) + $urandom_range(1, 40) : $urandom_range(0, 6);
      send_hdr(16'(c));
      if (c <= int'(DEPTH))
        for (int i = 0; i < c; i++) send_word($urandom);
      wait_status();
    end
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
